hdmi_line_fetcher: RTL and testbench

HDMI_LINE_FETCHER -- requirements
Module: hdmi_line_fetcher

---
 rtl/hdmi_line_fetcher.sv | 153 +++++++++++++++
 tb/tb_hdmi_line_fetcher.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_line_fetcher.sv
// Double-buffered scanline prefetcher: fills one line buffer from the framebuffer while the other feeds HDMI.
// Define LINE_FETCH_UNDERRUN_EN to build the sticky underrun flag; otherwise underrun is tied low.

module hdmi_line_fetcher #(
  parameter int FB_WIDTH  = 400,
  parameter int FB_HEIGHT = 240,
  parameter int ADDR_W    = 19
) (
  input  logic              pixclk,
  input  logic              reset,
  input  logic [10:0]       nextX,
  input  logic [10:0]       nextY,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       pixelData,
  output logic              underrun
);

  localparam int COL_W = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
  localparam int ROW_W = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;
  localparam logic [9:0]       X_ACTIVE = 10'(FB_WIDTH);
  localparam logic [10:0]      Y_ACTIVE = 11'(2 * FB_HEIGHT);
  localparam logic [10:0]      ROWS     = 11'(FB_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FB_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FULL} state_t;

  state_t           state_q, state_d;
  logic             rd_sel_q, rd_sel_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [10:0]      prev_x_q;
  logic             boot_q;
  logic             pix_valid_q, pix_valid_d;
  logic             pix_sel_q;
  logic             line_start, swap_point, frame_end, accept;
  logic [10:0]      next_row;
  logic [COL_W-1:0] rd_col;
  logic [15:0]      bank_rd [2];

  assign line_start  = (nextX == 11'd0) && (prev_x_q != 11'd0);
  assign swap_point  = line_start && !nextY[0] && (nextY < Y_ACTIVE);
  assign frame_end   = line_start && (nextY == Y_ACTIVE);
  assign next_row    = {1'b0, nextY[10:1]} + 11'd1;
  assign accept      = (state_q == S_FETCH) && mem_ack;
  assign pix_valid_d = (nextX[10:1] < X_ACTIVE) && (nextY < Y_ACTIVE);
  assign rd_col      = pix_valid_d ? COL_W'(nextX[10:1]) : '0;

  assign mem_req  = (state_q == S_FETCH);
  assign mem_addr = ADDR_W'(row_q) * ADDR_W'(FB_WIDTH) + ADDR_W'(col_q);

  always_comb begin
    state_d  = state_q;
    rd_sel_d = rd_sel_q;
    col_d    = col_q;
    row_d    = row_q;
    case (state_q)
      S_IDLE: begin
        // boot_q kicks off the row-0 fetch in the first cycle after reset
        if (boot_q || frame_end) begin
          state_d = S_FETCH;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_FETCH: begin
        if (mem_ack) begin
          if (col_q == COL_LAST) begin
            state_d = S_FULL;
            col_d   = '0;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_FULL: begin
        if (swap_point) begin
          rd_sel_d = ~rd_sel_q;
          if (next_row < ROWS) begin
            state_d = S_FETCH;
            row_d   = ROW_W'(next_row);
            col_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_sel_q    <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      prev_x_q    <= 11'd0;
      boot_q      <= 1'b1;
      pix_valid_q <= 1'b0;
      pix_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_sel_q    <= rd_sel_d;
      col_q       <= col_d;
      row_q       <= row_d;
      prev_x_q    <= nextX;
      boot_q      <= 1'b0;
      pix_valid_q <= pix_valid_d;
      pix_sel_q   <= rd_sel_q;
    end
  end

  // Each bank is written only while it is the fill target, so read and write never share a bank.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    localparam logic BANK = 1'(gi);
    logic [15:0] mem_a [FB_WIDTH];
    logic [15:0] rd_q;

    always_ff @(posedge pixclk) begin
      if (accept && (rd_sel_q != BANK)) begin
        mem_a[col_q] <= mem_rdata;
      end
      rd_q <= mem_a[rd_col];
    end

    assign bank_rd[gi] = rd_q;
  end

  assign pixelData = pix_valid_q ? bank_rd[pix_sel_q] : 16'h0000;

`ifdef LINE_FETCH_UNDERRUN_EN
  logic underrun_q;
  logic underrun_hit;

  assign underrun_hit = swap_point && (state_q != S_FULL);

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      underrun_q <= 1'b0;
    end else if (underrun_hit) begin
      underrun_q <= 1'b1;
    end
  end

  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_hdmi_line_fetcher.sv
// Scoreboard bench for hdmi_line_fetcher: request addresses and pixels are predicted when stimulus is driven.

module tb_hdmi_line_fetcher;

  localparam int W = 400;
  localparam int H = 240;
  localparam int L = 840;
`ifdef LINE_FETCH_UNDERRUN_EN
  localparam bit UNDERRUN_EN = 1'b1;
`else
  localparam bit UNDERRUN_EN = 1'b0;
`endif

  logic        pixclk = 1'b0;
  logic        reset;
  logic [10:0] nextX, nextY;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] pixelData;
  logic        underrun;

  hdmi_line_fetcher #(.FB_WIDTH(W), .FB_HEIGHT(H), .ADDR_W(19)) dut (
    .pixclk    (pixclk),
    .reset     (reset),
    .nextX     (nextX),
    .nextY     (nextY),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .pixelData (pixelData),
    .underrun  (underrun)
  );

  always #5 pixclk = ~pixclk;

  typedef struct {
    logic        chk;
    logic [15:0] val;
  } pix_exp_t;

  pix_exp_t    pix_q[$];
  int unsigned addr_q[$];
  int          checks, failures;
  int          lat, ack_cnt;
  bit          hold_ack, spur_ack;
  int          prev_x, disp_row, fill_row;
  bit          disp_known, fill_valid, allow_swap, exp_underrun;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_row(input int r);
    for (int c = 0; c < W; c++) addr_q.push_back(int'(r * W + c));
  endtask

  // One clock: compare last cycle's pixel, then play the memory for the coming edge.
  task automatic tick();
    pix_exp_t e;
    @(negedge pixclk);
    if (pix_q.size() > 0) begin
      e = pix_q.pop_front();
      if (e.chk) check_eq("pixel", pixelData, e.val);
    end
    mem_ack = 1'b0;
    if (spur_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = 16'hDEAD;
    end else if (!hold_ack && !reset && mem_req) begin
      if (lat == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_addr[15:0];
        ack_cnt++;
        check_eq("req_addr", mem_addr, (addr_q.size() > 0) ? addr_q.pop_front() : 32'hFFFF_FFFF);
        lat = $urandom_range(0, 3);
      end else begin
        lat--;
      end
    end
  endtask

  task automatic drive(input int x, input int y);
    bit       ls, chk;
    int       xh;
    pix_exp_t e;
    tick();
    nextX = 11'(x);
    nextY = 11'(y);
    ls     = (x == 0) && (prev_x != 0);
    prev_x = x;
    xh     = x / 2;
    chk    = (x <= 3) || (x % 13 == 0) || (x >= 796 && x <= 802) || x == 6 || x == 10;
    if (xh < W && y < 2 * H) begin
      e.chk = chk && disp_known;
      e.val = 16'(disp_row * W + xh);
    end else begin
      e.chk = chk;
      e.val = 16'h0000;
    end
    pix_q.push_back(e);
    if (ls && y < 2 * H && y % 2 == 0) begin
      if (allow_swap) begin
        disp_row   = fill_row;
        disp_known = 1'b1;
        if (y / 2 + 1 < H) begin
          fill_row = y / 2 + 1;
          push_row(fill_row);
        end else begin
          fill_valid = 1'b0;
        end
      end else begin
        exp_underrun = 1'b1;
      end
    end else if (ls && y == 2 * H && !fill_valid) begin
      fill_row   = 0;
      fill_valid = 1'b1;
      push_row(0);
    end
  endtask

  task automatic drive_line(input int y);
    for (int x = 0; x < L; x++) begin
      drive(x, y);
      if ((y == 2 * H - 2 || y == 2 * H - 1) && (x == 100 || x == 700))
        check_eq("no_req_tail", mem_req, 0);
    end
  endtask

  task automatic wait_drain(input string tag, input int bound);
    for (int i = 0; i < bound && addr_q.size() > 0; i++) tick();
    check_eq(tag, addr_q.size(), 0);
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    #1;
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_pixel", pixelData, 0);
    check_eq("rst_underrun", underrun, 0);
    tick();
    tick();
    reset        = 1'b0;
    prev_x       = 0;
    lat          = 0;
    fill_row     = 0;
    fill_valid   = 1'b1;
    exp_underrun = 1'b0;
    pix_q.delete();
    addr_q.delete();
    push_row(0);
  endtask

  initial begin
    checks = 0; failures = 0; lat = 0; ack_cnt = 0;
    hold_ack = 1'b0; spur_ack = 1'b0; allow_swap = 1'b1;
    disp_known = 1'b0; disp_row = 0; fill_row = 0; fill_valid = 1'b1;
    prev_x = 0; exp_underrun = 1'b0;
    reset = 1'b1; nextX = 11'd0; nextY = 11'd500; mem_ack = 1'b0; mem_rdata = 16'h0;

    repeat (3) @(negedge pixclk);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_pixel", pixelData, 0);
    check_eq("rst_underrun", underrun, 0);
    reset = 1'b0;
    push_row(0);

    wait_drain("fill0_drain", 3000);
    tick(); tick();
    check_eq("full_no_req", mem_req, 0);
    check_eq("full_underrun", underrun, 0);

    spur_ack = 1'b1;
    repeat (4) tick();
    spur_ack = 1'b0;
    tick();
    check_eq("spur_no_req", mem_req, 0);
    check_eq("spur_addr", mem_addr, 0);

    drive(900, 500);
    for (int y = 0; y < 4; y++) drive_line(y);
    for (int y = 2 * H - 6; y < 2 * H + 2; y++) drive_line(y);
    check_eq("frame_underrun", underrun, 0);
    wait_drain("prefetch_drain", 2000);

    // Buffer 0 now holds row 0; it stays the display buffer across reset.
    do_reset();
    disp_known = 1'b1;
    disp_row   = 0;
    ack_cnt    = 0;
    for (int i = 0; i < 2000 && ack_cnt < 150; i++) tick();
    check_eq("acks150", ack_cnt, 150);
    hold_ack = 1'b1;
    tick();
    do_reset();
    repeat (3) tick();
    check_eq("restart_req", mem_req, 1);
    check_eq("restart_addr", mem_addr, 0);

    allow_swap = 1'b0;
    drive(900, 0);
    drive_line(0);
    tick();
    check_eq("underrun_set", underrun, UNDERRUN_EN ? exp_underrun : 1'b0);
    check_eq("underrun_req", mem_req, 1);
    check_eq("underrun_addr", mem_addr, 0);

    hold_ack   = 1'b0;
    allow_swap = 1'b1;
    wait_drain("final_drain", 3000);
    tick(); tick();
    check_eq("final_no_req", mem_req, 0);
    check_eq("underrun_sticky", underrun, UNDERRUN_EN ? exp_underrun : 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
